// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: word width, ALU control codes and sequencer encodings shared by the MUL/UDIV sequencer.
package alu_muldiv_seq_pkg;
  localparam int WORD = 64;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic MULDIV_OP_MUL = 1'b0;
  localparam logic MULDIV_OP_DIV = 1'b1;
  typedef enum logic [1:0] {MULDIV_IDLE, MULDIV_MUL_STEP, MULDIV_DIV_STEP, MULDIV_DONE} muldiv_state_t;
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterates the shared ALU to run MUL (shift-add) and UDIV (restoring); early exit under MULDIV_EARLY_EXIT_EN.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co
);
  muldiv_state_t state;
  logic [WIDTH-1:0] acc, mc, q, shl, acc_m, rem_d, q_d;
  logic [CNT_W-1:0] cnt;
  logic take, last, mul_exit, div_early;
  always_comb begin
    shl = {acc[WIDTH-2:0], q[WIDTH-1]};
    alu_ctl = state == MULDIV_MUL_STEP ? ALU_ADD : state == MULDIV_DIV_STEP ? ALU_SUB : ALU_PASS;
    alu_a = state == MULDIV_MUL_STEP ? acc : state == MULDIV_DIV_STEP ? shl : '0;
    alu_b = (state == MULDIV_MUL_STEP || state == MULDIV_DIV_STEP) ? mc : '0;
    // a shifted-out 1 means the partial remainder already exceeds any divisor
    take = acc[WIDTH-1] | alu_co;
    acc_m = q[0] ? alu_out : acc;
    rem_d = take ? alu_out : shl;
    q_d = {q[WIDTH-2:0], take};
    last = cnt == CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_EXIT_EN
    mul_exit = last || q[WIDTH-1:1] == '0;
    div_early = cnt == '0 && q < mc;
`else
    mul_exit = last;
    div_early = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MULDIV_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      remainder <= '0;
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      q <= '0;
    end else begin
      case (state)
        MULDIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc <= '0;
            mc <= op_div ? opnd_b : opnd_a;
            q <= op_div ? opnd_a : opnd_b;
            cnt <= '0;
            busy <= 1'b1;
            if (op_div == MULDIV_OP_DIV && opnd_b == '0) begin
              state <= MULDIV_DONE;
              done <= 1'b1;
              result <= '0;
              remainder <= '0;
            end else begin
              state <= op_div ? MULDIV_DIV_STEP : MULDIV_MUL_STEP;
            end
          end
        end
        MULDIV_MUL_STEP: begin
          acc <= acc_m;
          mc <= mc << 1;
          q <= q >> 1;
          cnt <= cnt + 1'b1;
          if (mul_exit) begin
            state <= MULDIV_DONE;
            done <= 1'b1;
            result <= acc_m;
            remainder <= '0;
          end
        end
        MULDIV_DIV_STEP: begin
          if (div_early) begin
            state <= MULDIV_DONE;
            done <= 1'b1;
            result <= '0;
            remainder <= q;
          end else begin
            acc <= rem_d;
            q <= q_d;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= MULDIV_DONE;
              done <= 1'b1;
              result <= q_d;
              remainder <= rem_d;
            end
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= MULDIV_IDLE;
        end
      endcase
    end
  end
endmodule
